// File: rtl/types_pkg.sv
// Shared micro-op and writeback types for the ALU reservation station.
// Type definitions only; no timing or flow-control behaviour.
package types_pkg;

    localparam int ALU_RS_DEPTH = 8;
    localparam int ALU_RS_AGE_W = 3;
    localparam int PREG_W       = 7;

    typedef struct packed {
        logic              valid;
        logic [2:0]        age;
        logic [4:0]        rob_index;
        logic [3:0]        opcode;
        logic [31:0]       imm;
        logic [1:0]        fu;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
    } alu_rs_data;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] prd;
    } wb_bcast_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: one-hot grant and index of the smallest age among requests.
// Purely combinational; no flow control of its own.
module rs_age_select
    import types_pkg::*;
#(
    parameter int DEPTH = ALU_RS_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]        req,
    input  logic [ALU_RS_AGE_W-1:0] age [DEPTH],
    output logic [DEPTH-1:0]        grant,
    output logic [IDX_W-1:0]        idx,
    output logic                    any
);

    logic [ALU_RS_AGE_W-1:0] best;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        best  = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && (!any || (age[i] < best))) begin
                any  = 1'b1;
                best = age[i];
                idx  = IDX_W'(i);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_rs_issue_scheduler.sv
// ALU reservation station: CDB wakeup, oldest-ready issue; dispatch->issue 1 cycle.
// Dispatch stalls while full (registered count); issue holds until issue_ready.
module alu_rs_issue_scheduler
    import types_pkg::*;
#(
    parameter int DEPTH    = ALU_RS_DEPTH,
    parameter int WB_PORTS = 2,
    localparam int CNT_W   = $clog2(DEPTH) + 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             disp_valid,
    output logic                             disp_ready,
    input  alu_rs_data                       disp_data,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS-1:0][PREG_W-1:0]  wb_prd,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output alu_rs_data                       issue_data,
    output logic [CNT_W-1:0]                 count
);

    alu_rs_data ent_q [DEPTH];
    alu_rs_data ent_d [DEPTH];
    alu_rs_data new_ent;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    wb_bcast_t [WB_PORTS-1:0] wb;

    logic [DEPTH-1:0]        cand;
    logic [ALU_RS_AGE_W-1:0] ages [DEPTH];
    logic [DEPTH-1:0]        sel_grant;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_any;
    logic [ALU_RS_AGE_W-1:0] sel_age;
    logic [IDX_W-1:0]        alloc_idx;
    logic                    disp_fire;
    logic                    issue_fire;

    function automatic logic tag_woken(input wb_bcast_t [WB_PORTS-1:0] bc,
                                       input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (bc[k].valid && (bc[k].prd == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int k = 0; k < WB_PORTS; k++) begin
            wb[k].valid = wb_valid[k];
            wb[k].prd   = wb_prd[k];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = ent_q[i].valid && ent_q[i].pr1_ready && ent_q[i].pr2_ready;
            ages[i] = ent_q[i].age;
        end
    end

    rs_age_select #(.DEPTH(DEPTH)) u_select (
        .req   (cand),
        .age   (ages),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign sel_age     = ent_q[sel_idx].age;
    assign issue_valid = sel_any;
    assign issue_data  = sel_any ? ent_q[sel_idx] : '0;
    assign disp_ready  = (count_q < CNT_W'(DEPTH));
    assign count       = count_q;
    assign disp_fire   = disp_valid && disp_ready;
    assign issue_fire  = issue_valid && issue_ready;

    // Lowest free slot; a slot freed by a same-cycle issue is not reused yet.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        new_ent           = disp_data;
        new_ent.valid     = 1'b1;
        new_ent.age       = ALU_RS_AGE_W'(count_q - CNT_W'(issue_fire));
        new_ent.pr1_ready = disp_data.pr1_ready || (disp_data.pr1 == '0)
                            || tag_woken(wb, disp_data.pr1);
        new_ent.pr2_ready = disp_data.pr2_ready || (disp_data.pr2 == '0)
                            || tag_woken(wb, disp_data.pr2);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].valid) begin
                    if (tag_woken(wb, ent_q[i].pr1)) ent_d[i].pr1_ready = 1'b1;
                    if (tag_woken(wb, ent_q[i].pr2)) ent_d[i].pr2_ready = 1'b1;
                    if (issue_fire) begin
                        if (sel_grant[i]) begin
                            ent_d[i].valid = 1'b0;
                        end else if (ent_q[i].age > sel_age) begin
                            ent_d[i].age = ent_q[i].age - 1'b1;
                        end
                    end
                end
            end
            if (disp_fire) begin
                ent_d[alloc_idx] = new_ent;
            end
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

    // Ages of live entries must be a permutation of 0..count-1.
    logic [CNT_W-1:0]             pop;
    logic                         ages_ok;
    logic [2**ALU_RS_AGE_W-1:0]   seen;

    always_comb begin
        pop     = '0;
        ages_ok = 1'b1;
        seen    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                pop = pop + 1'b1;
                if (seen[ent_q[i].age] || (CNT_W'(ent_q[i].age) >= count_q)) begin
                    ages_ok = 1'b0;
                end
                seen[ent_q[i].age] = 1'b1;
            end
        end
    end

    a_rs_invariant: assert property (@(posedge clk) disable iff (!rst_n)
        ages_ok && (pop == count_q));

endmodule

// File: tb/tb_alu_rs_issue_scheduler.sv
// Randomised and directed stimulus against an age-ordered queue model of the RS.
// Expected per-cycle status and issued uops are queued and checked by a monitor.
module tb_alu_rs_issue_scheduler;
    import types_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    alu_rs_data       disp_data;
    logic [1:0]       wb_valid;
    logic [1:0][6:0]  wb_prd;
    logic             issue_valid;
    logic             issue_ready;
    alu_rs_data       issue_data;
    logic [3:0]       count;

    alu_rs_issue_scheduler #(.DEPTH(8), .WB_PORTS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_data   (disp_data),
        .wb_valid    (wb_valid),
        .wb_prd      (wb_prd),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_data  (issue_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit dr;
        bit iv;
    } st_t;

    alu_rs_data mq[$];        // model: oldest first, position == age
    st_t        status_q[$];
    alu_rs_data issue_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (status_q.size() != 0) begin
            st_t s;
            s = status_q.pop_front();
            chk("count", 128'(count), 128'(s.cnt));
            chk("disp_ready", 128'(disp_ready), 128'(s.dr));
            chk("issue_valid", 128'(issue_valid), 128'(s.iv));
        end
        if (rst_n && !flush && issue_valid && issue_ready) begin
            if (issue_q.size() == 0) begin
                chk("unexpected_issue", 128'(issue_data), 128'(0));
            end else begin
                chk("issue_data", 128'(issue_data), 128'(issue_q.pop_front()));
            end
        end
    end

    function automatic bit woke(input logic [6:0] t, input logic [1:0] wv,
                                input logic [6:0] a, input logic [6:0] b);
        return (wv[0] && a == t) || (wv[1] && b == t);
    endfunction

    function automatic alu_rs_data mk(input logic [6:0] p1, input logic r1,
                                      input logic [6:0] p2, input logic r2);
        alu_rs_data u;
        u.valid     = 1'($urandom);
        u.age       = 3'($urandom);
        u.rob_index = 5'($urandom);
        u.opcode    = 4'($urandom);
        u.imm       = $urandom;
        u.fu        = 2'($urandom);
        u.prd       = 7'($urandom);
        u.pr1       = p1;
        u.pr1_ready = r1;
        u.pr2       = p2;
        u.pr2_ready = r2;
        return u;
    endfunction

    // Drive one cycle of inputs, derive expectations from the model, advance it.
    task automatic cycle(input bit rs, input bit fl, input bit dv, input alu_rs_data d,
                         input logic [1:0] wv, input logic [6:0] p0, input logic [6:0] p1,
                         input bit ir);
        int sz;
        int cnd;
        alu_rs_data e;
        rst_n       = rs;
        flush       = fl;
        disp_valid  = dv;
        disp_data   = d;
        wb_valid    = wv;
        wb_prd[0]   = p0;
        wb_prd[1]   = p1;
        issue_ready = ir;
        sz = mq.size();
        if (!rs) begin
            mq.delete();
            status_q.push_back('{0, 1'b1, 1'b0});
        end else begin
            cnd = -1;
            for (int i = 0; i < sz; i++) begin
                if (cnd < 0 && mq[i].pr1_ready && mq[i].pr2_ready) cnd = i;
            end
            status_q.push_back('{sz, sz < 8, cnd >= 0});
            if (fl) begin
                mq.delete();
            end else begin
                if (cnd >= 0 && ir) begin
                    e = mq[cnd];
                    e.valid = 1'b1;
                    e.age = 3'(cnd);
                    issue_q.push_back(e);
                end
                for (int i = 0; i < sz; i++) begin
                    if (woke(mq[i].pr1, wv, p0, p1)) mq[i].pr1_ready = 1'b1;
                    if (woke(mq[i].pr2, wv, p0, p1)) mq[i].pr2_ready = 1'b1;
                end
                if (cnd >= 0 && ir) mq.delete(cnd);
                if (dv && sz < 8) begin
                    e = d;
                    e.valid = 1'b1;
                    e.age = 3'(mq.size());
                    e.pr1_ready = d.pr1_ready || d.pr1 == 0 || woke(d.pr1, wv, p0, p1);
                    e.pr2_ready = d.pr2_ready || d.pr2 == 0 || woke(d.pr2, wv, p0, p1);
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, 2'b00, 0, 0, ir);
    endtask

    task automatic disp(input alu_rs_data d, input bit ir);
        cycle(1, 0, 1, d, 2'b00, 0, 0, ir);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_data = '0;
        wb_valid = '0; wb_prd = '0; issue_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, '0, 2'b00, 0, 0, 0);
        idle(1, 0);

        // Reset mid-run with five waiting entries.
        for (int i = 0; i < 5; i++) disp(mk(7'd40, 0, 7'd41, 0), 0);
        cycle(0, 0, 0, '0, 2'b00, 0, 0, 1);
        idle(2, 1);

        // Two-step wakeup: issue only after the second tag arrives.
        disp(mk(7'd5, 0, 7'd6, 0), 1);
        idle(2, 1);
        cycle(1, 0, 0, '0, 2'b01, 7'd5, 0, 1);
        idle(2, 1);
        cycle(1, 0, 0, '0, 2'b10, 0, 7'd6, 1);
        idle(3, 1);

        // Three ready uops held back, then drained oldest first.
        for (int i = 0; i < 3; i++) disp(mk(7'd0, 0, 7'd33, 1), 0);
        idle(3, 0);
        idle(4, 1);

        // Fill to capacity, reject a ninth, then free one slot.
        for (int i = 0; i < 8; i++) disp(mk(7'(50 + i), 0, 7'd0, 0), 0);
        disp(mk(7'd0, 1, 7'd0, 1), 0);
        cycle(1, 0, 0, '0, 2'b01, 7'd53, 0, 0);
        idle(2, 1);
        disp(mk(7'd70, 0, 7'd71, 0), 0);
        cycle(1, 1, 0, '0, 2'b00, 0, 0, 0);

        // Dispatch-cycle wakeup capture and p0 operand.
        cycle(1, 0, 1, mk(7'd9, 0, 7'd10, 1), 2'b10, 0, 7'd9, 0);
        disp(mk(7'd11, 1, 7'd0, 0), 0);
        idle(3, 1);

        // Simultaneous dispatch and issue at count 4, then flush with dispatch.
        disp(mk(7'd60, 0, 7'd0, 1), 0);
        disp(mk(7'd0, 1, 7'd0, 1), 0);
        disp(mk(7'd61, 0, 7'd0, 1), 0);
        disp(mk(7'd62, 0, 7'd0, 1), 0);
        disp(mk(7'd63, 0, 7'd0, 1), 1);
        idle(1, 0);
        cycle(1, 1, 1, mk(7'd0, 1, 7'd0, 1), 2'b00, 0, 0, 1);
        idle(2, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bit rs;
            bit fl;
            rs = ($urandom_range(0, 499) != 0);
            fl = ($urandom_range(0, 63) == 0);
            cycle(rs, fl, $urandom_range(0, 9) < 7,
                  mk(7'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                     7'($urandom_range(0, 15)), $urandom_range(0, 3) == 0),
                  2'($urandom), 7'($urandom_range(1, 15)), 7'($urandom_range(1, 15)),
                  $urandom_range(0, 9) < 6);
        end
        idle(12, 1);
        @(negedge clk);
        chk("issue_q_drained", 128'(issue_q.size()), 128'(0));
        chk("status_q_drained", 128'(status_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
